sa_os_drain: RTL and testbench

- Result-readout engine for the output-stationary systolic array: the counterpart to the input feeders that write operands in.
- After the array finishes accumulating, it shifts the array's stored results out one column per shift.
- Each captured column is serialized into a valid/ready element stream: column-major order, row 0 first, with coordinates.
- Sits between the systolic array's edge-column readout port and the output writeback path.

---
 rtl/sa_os_drain.sv | 142 ++++++++++++++
 tb/tb_sa_os_drain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_os_drain.sv
// Drains an output-stationary systolic array one column per shift into a column-major element stream.
// Latency: first element 2 cycles after start. Stalls in EMIT while out_ready=0. Optional SA_DRAIN_PREFETCH_EN adds a shadow column buffer.
module sa_os_drain #(
  parameter int N      = 16,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  array_shift,
  input  logic [N*DATA_W-1:0]   array_col_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [$clog2(N)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_last
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N*DATA_W-1:0] r_col_buf;
  logic [IW-1:0]       r_row;
  logic [IW-1:0]       r_col;
  logic                w_hs;
  logic                w_row_end;
  logic                w_col_end;
  logic                w_swap;
  logic                w_fill;

`ifdef SA_DRAIN_PREFETCH_EN
  localparam int FW = $clog2(N + 1);
  logic [N*DATA_W-1:0] r_shadow;
  logic                r_shadow_full;
  logic [FW-1:0]       r_fetched;

  // Refill the shadow as soon as it is free so the next column is ready at the column boundary.
  assign w_fill = (r_state == EMIT) && !r_shadow_full && (r_fetched < FW'(N));
  assign w_swap = r_shadow_full;
`else
  assign w_fill = 1'b0;
  assign w_swap = 1'b0;
`endif

  assign w_hs      = (r_state == EMIT) && out_ready;
  assign w_row_end = (r_row == LAST_IDX);
  assign w_col_end = (r_col == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: w_next = EMIT;
      EMIT: if (w_hs && w_row_end) w_next = w_col_end ? DONE : (w_swap ? EMIT : LOAD);
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    out_valid   = (r_state == EMIT);
    array_shift = (r_state == LOAD) || w_fill;
    out_data    = '0;
    out_row     = '0;
    out_col     = '0;
    out_last    = 1'b0;
    if (r_state == EMIT) begin
      out_data = r_col_buf[int'(r_row)*DATA_W +: DATA_W];
      out_row  = r_row;
      out_col  = r_col;
      out_last = w_row_end && w_col_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_buf     <= '0;
      r_row         <= '0;
      r_col         <= '0;
`ifdef SA_DRAIN_PREFETCH_EN
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_fetched     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_row <= '0;
          r_col <= '0;
`ifdef SA_DRAIN_PREFETCH_EN
          r_shadow_full <= 1'b0;
          r_fetched     <= '0;
`endif
        end
        LOAD: begin
          r_col_buf <= array_col_data;
`ifdef SA_DRAIN_PREFETCH_EN
          r_fetched <= r_fetched + 1'b1;
`endif
        end
        EMIT: if (w_hs) begin
          if (!w_row_end) begin
            r_row <= r_row + 1'b1;
          end else if (!w_col_end) begin
            r_row <= '0;
            r_col <= r_col + 1'b1;
`ifdef SA_DRAIN_PREFETCH_EN
            if (r_shadow_full) begin
              r_col_buf     <= r_shadow;
              r_shadow_full <= 1'b0;
            end
`endif
          end
        end
        default: ;
      endcase
`ifdef SA_DRAIN_PREFETCH_EN
      // Fill only happens with the shadow empty, so it never collides with the swap above.
      if (w_fill) begin
        r_shadow      <= array_col_data;
        r_shadow_full <= 1'b1;
        r_fetched     <= r_fetched + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sa_os_drain.sv
// Randomized scoreboard bench for sa_os_drain: array model, column-major expectation queue, stream monitor.
module tb_sa_os_drain;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int IW = $clog2(N);
`ifdef SA_DRAIN_PREFETCH_EN
  localparam int LAT = 1 + N * N;
`else
  localparam int LAT = N * (N + 1);
`endif
  localparam int LIM = 8 * N * N + 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, array_shift;
  logic [N*DW-1:0]   array_col_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_row, out_col;
  logic              out_last;

  sa_os_drain #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .array_shift(array_shift), .array_col_data(array_col_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    logic          last;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int shift_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int ready_mode = 0;

  // Array model: each shift exposes the next column at the edge.
  logic [DW-1:0] arr [N][N];
  int sidx = 0;
  int sbase = 0;

  always_comb begin
    array_col_data = '0;
    for (int r = 0; r < N; r++)
      if (sidx - sbase < N) array_col_data[r*DW +: DW] = arr[r][sidx - sbase];
  end

  always @(posedge clk) if (array_shift) sidx <= sidx + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input bit rrcc);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        arr[r][c] = rrcc ? DW'((r << 8) | c) : DW'($urandom);
    sbase = sidx;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++) begin
        e.d = arr[r][c];
        e.r = r;
        e.c = c;
        e.last = (r == N - 1) && (c == N - 1);
        q.push_back(e);
      end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  bit            stall_pend = 0;
  logic [DW-1:0] sv_d;
  logic [IW-1:0] sv_r, sv_c;
  logic          sv_l;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (array_shift) begin
        shift_cnt++;
        if (!busy) chk("shift_while_idle", 0, 1);
`ifndef SA_DRAIN_PREFETCH_EN
        if (out_valid) chk("shift_during_emit", 1, 0);
`endif
      end
      if (stall_pend) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_stable", {out_data, out_row, out_col, out_last}, {sv_d, sv_r, sv_c, sv_l});
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_elem", 1, 0);
        end else begin
          chk("elem_data", out_data, q[0].d);
          chk("elem_rc", {out_row, out_col}, {IW'(q[0].r), IW'(q[0].c)});
          chk("elem_last", out_last, q[0].last);
          void'(q.pop_front());
        end
      end
      stall_pend = out_valid && !out_ready;
      sv_d = out_data; sv_r = out_row; sv_c = out_col; sv_l = out_last;
      if (done) begin
        done_cnt++;
        chk("queue_empty_at_done", q.size(), 0);
      end
    end
  end

  initial begin
    int pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (pat == 0) || (pat == 3); pat = (pat + 1) % 4; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // One full drain from an IDLE cycle (posedge+1); returns in the first IDLE cycle after done.
  task automatic drain(input int rmode, input bit xstart, input bit chk_lat, input bit sod);
    int s0, d0, lat;
    bit seen;
    ready_mode = rmode;
    s0 = shift_cnt;
    d0 = done_cnt;
    seen = 0;
    lat = -1;
    push_exp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < LIM && !seen; i++) begin
      if (i == 0) chk("load_shift", array_shift, 1);
      if (done) begin seen = 1; lat = i; end
      start = (xstart && (i == 3 || i == 10)) || (sod && done);
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("drain_finished", seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_lat) chk("load_to_done_cycles", lat, LAT);
    chk("shift_pulses", shift_cnt - s0, N);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int h0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_shift", array_shift, 0);
    chk("rst_outs", {out_data, out_row, out_col, out_last}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(1); drain(0, 0, 1, 0);
    repeat (2) @(posedge clk); #1;
    fill(1); drain(1, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    fill(0); drain(2, 1, 0, 0);
    repeat (2) @(posedge clk); #1;
    fill(0); drain(2, 0, 0, 1);
    chk("start_on_done_ignored_busy", busy, 0);
    @(posedge clk); #1;
    chk("start_on_done_still_idle", {busy, out_valid, array_shift}, 0);

    // Reset after six handshakes of a drain.
    fill(0);
    push_exp();
    ready_mode = 2;
    h0 = hs_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < LIM && hs_cnt < h0 + 6; i++) begin @(posedge clk); #1; end
    chk("mid_drain_progress", hs_cnt - h0 >= 6, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_idle", {busy, out_valid, array_shift, done}, 0);
    rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    fill(0); drain(2, 0, 0, 0);

    // Back-to-back: second start in the first cycle after done drops.
    repeat (2) @(posedge clk); #1;
    fill(0); drain(0, 0, 1, 0);
    fill(0); drain(2, 0, 0, 0);

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
